// File: rtl/seg7_scan_controller_if.sv
// seg7_scan_controller_if: user-side data/load bus and display pin bundle for the 7-seg scanner
interface seg7_scan_controller_if #(
    parameter int NUM_DIGITS = 4
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic [NUM_DIGITS-1:0]   an;
    logic [6:0]              seg;
    logic                    dp;
    logic                    frame_done;

    modport master (
        output value, digit_en, dp_in, load,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  value, digit_en, dp_in, load,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg7_scan_controller.sv
// seg7_scan_controller: common-anode 7-seg scanner with per-slot blanking and frame-synchronous commit; define SEG7_LZ_BLANK_EN for leading-zero suppression
module seg7_scan_controller #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input logic                   clk,
    input logic                   rst_n,
    seg7_scan_controller_if.slave bus
);
    localparam int CW = $clog2(REFRESH_DIV);
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [0:0] BLANK = 1'b0;
    localparam logic [0:0] DRIVE = 1'b1;

    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx;
    logic [0:0]            state;
    logic [VW-1:0]         pend_value, act_value;
    logic [NUM_DIGITS-1:0] pend_en, pend_dp, act_en, act_dp;
    logic                  pend_valid;
    logic                  wrap, boundary, lz, lit;
    logic [3:0]            nib;
    logic [6:0]            glyph;

    assign wrap     = cnt == CNT_MAX;
    assign boundary = wrap && idx == IDX_MAX;

    // Slot counter, digit index and BLANK/DRIVE state; state tracks the counter value it accompanies
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            idx   <= '0;
            state <= BLANK;
        end else begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            if (wrap) idx <= idx == IDX_MAX ? '0 : idx + 1'b1;
            state <= (wrap || int'(cnt) + 1 < BLANK_CYCLES) ? BLANK : DRIVE;
        end
    end

    // Pending/active double buffer: loads land in pending, a load on the boundary goes straight to active
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_value <= '0;
            pend_en    <= '0;
            pend_dp    <= '0;
            pend_valid <= 1'b0;
            act_value  <= '0;
            act_en     <= '0;
            act_dp     <= '0;
        end else if (boundary) begin
            pend_valid <= 1'b0;
            if (bus.load) begin
                act_value <= bus.value;
                act_en    <= bus.digit_en;
                act_dp    <= bus.dp_in;
            end else if (pend_valid) begin
                act_value <= pend_value;
                act_en    <= pend_en;
                act_dp    <= pend_dp;
            end
        end else if (bus.load) begin
            pend_value <= bus.value;
            pend_en    <= bus.digit_en;
            pend_dp    <= bus.dp_in;
            pend_valid <= 1'b1;
        end
    end

    // Current nibble, suppression and whether this cycle actually drives an anode
    always_comb begin
        nib = act_value[4*idx +: 4];
`ifdef SEG7_LZ_BLANK_EN
        lz  = idx != '0 && (act_value >> {idx, 2'b00}) == '0;
`else
        lz  = 1'b0;
`endif
        lit = state == DRIVE && act_en[idx] && !lz;
    end

    // Active-low hex glyph table, segments ordered {g,f,e,d,c,b,a}
    always_comb begin
        glyph = 7'h7F;
        case (nib)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
        endcase
    end

    // Registered pin drive; anything not lit is fully dark
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.an         <= '1;
            bus.seg        <= 7'h7F;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            bus.an         <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            bus.seg        <= lit ? glyph : 7'h7F;
            bus.dp         <= lit ? ~act_dp[idx] : 1'b1;
            bus.frame_done <= boundary;
        end
    end
endmodule

// File: tb/tb_seg7_scan_controller.sv
// tb_seg7_scan_controller: directed checks of scan timing, commit, enables, leading zeros and anode invariants
module tb_seg7_scan_controller;
    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G2   = 7'b0100100;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] GA   = 7'b0001000;
    localparam logic [6:0] GF   = 7'b0001110;
    localparam logic [6:0] DARK = 7'h7F;

    logic clk, rst_n;
    int   n_tests, n_fail;
    logic [3:0] cap_an [32];
    logic [6:0] cap_seg [32];
    logic       cap_dp [32];
    logic       cap_fd [32];

    seg7_scan_controller_if #(.NUM_DIGITS(4)) bus ();

    seg7_scan_controller #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] en, input logic [3:0] d);
        bus.value    = v;
        bus.digit_en = en;
        bus.dp_in    = d;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load     = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 100);
        n_tests++;
        if (bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_frame_wait: frame_done=%b, want 1 within 100 cycles", name, bus.frame_done);
        end
    endtask

    task automatic capture(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            cap_an[k]  = bus.an;
            cap_seg[k] = bus.seg;
            cap_dp[k]  = bus.dp;
            cap_fd[k]  = bus.frame_done;
        end
    endtask

    // Expected {an,seg,dp} at frame position j (slot j/8, cycle j%8) for hand-given per-digit glyphs
    function automatic logic [11:0] exp_at(input int j, input logic [3:0] lit, input logic [27:0] gl, input logic [3:0] dpl);
        int   d;
        logic drv;
        d   = j / 8;
        drv = (j % 8) >= 2 && lit[d];
        return drv ? {~(4'b0001 << d), gl[7*d +: 7], ~dpl[d]} : {4'hF, DARK, 1'b1};
    endfunction

    task automatic test_reset();
        int n;
        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.value    = '0;
        bus.digit_en = '0;
        bus.dp_in    = '0;
        step(3);
        n_tests++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, DARK, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_initial: an=%b seg=%b dp=%b fd=%b, want 1111 1111111 1 0", bus.an, bus.seg, bus.dp, bus.frame_done);
        end
        rst_n = 1'b1;
        do_load(16'h8888, 4'hF, 4'h0);
        wait_frame("reset_pre");
        step(4);
        n_tests++;
        if ({bus.an, bus.seg} !== {4'b1110, 7'b0000000}) begin
            n_fail++;
            $display("FAIL reset_mid_drive: an=%b seg=%b, want 1110 0000000", bus.an, bus.seg);
        end
        do_load(16'h1234, 4'hF, 4'hF);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.an, bus.seg, bus.dp, bus.frame_done} !== {4'hF, DARK, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_async: an=%b seg=%b dp=%b fd=%b, want 1111 1111111 1 0", bus.an, bus.seg, bus.dp, bus.frame_done);
        end
        step(2);
        rst_n = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.frame_done && n < 100);
        n_tests++;
        if (n !== 32) begin
            n_fail++;
            $display("FAIL reset_first_frame: frame_done after %0d cycles, want 32", n);
        end
        capture(32);
        for (int j = 0; j < 32; j++) begin
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== {4'hF, DARK, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_dark[%0d]: an=%b seg=%b dp=%b, want 1111 1111111 1", j, cap_an[j], cap_seg[j], cap_dp[j]);
            end
        end
    endtask

    task automatic test_basic_scan();
        logic [11:0] e;
        do_load(16'h12AF, 4'hF, 4'h0);
        wait_frame("basic");
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_at(j, 4'hF, {G1, G2, GA, GF}, 4'h0);
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== e) begin
                n_fail++;
                $display("FAIL basic_scan[%0d]: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", j, cap_an[j], cap_seg[j], cap_dp[j], e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_tearing();
        logic [11:0] e;
        wait_frame("tear");
        do_load(16'h1111, 4'hF, 4'h0);
        do_load(16'h2222, 4'hF, 4'h0);
        capture(30);
        for (int k = 0; k < 30; k++) begin
            e = exp_at(k + 2, 4'hF, {G1, G2, GA, GF}, 4'h0);
            n_tests++;
            if ({cap_an[k], cap_seg[k], cap_dp[k], cap_fd[k]} !== {e, k == 29}) begin
                n_fail++;
                $display("FAIL tear_old[%0d]: an=%b seg=%b dp=%b fd=%b, want an=%b seg=%b dp=%b fd=%b", k + 2, cap_an[k], cap_seg[k], cap_dp[k], cap_fd[k], e[11:8], e[7:1], e[0], k == 29);
            end
        end
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_at(j, 4'hF, {4{G2}}, 4'h0);
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== e) begin
                n_fail++;
                $display("FAIL tear_new[%0d]: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", j, cap_an[j], cap_seg[j], cap_dp[j], e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_boundary_load();
        logic [11:0] e;
        wait_frame("bnd");
        step(31);
        bus.value    = 16'h3333;
        bus.digit_en = 4'hF;
        bus.dp_in    = 4'h0;
        bus.load     = 1'b1;
        @(negedge clk);
        bus.load = 1'b0;
        n_tests++;
        if (bus.frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL bnd_align: frame_done=%b, want 1", bus.frame_done);
        end
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_at(j, 4'hF, {4{G3}}, 4'h0);
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== e) begin
                n_fail++;
                $display("FAIL bnd_commit[%0d]: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", j, cap_an[j], cap_seg[j], cap_dp[j], e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_enables_dp();
        logic [11:0] e;
        do_load(16'h12AF, 4'b0101, 4'b0010);
        wait_frame("en");
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_at(j, 4'b0101, {G1, G2, GA, GF}, 4'b0010);
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== e) begin
                n_fail++;
                $display("FAIL en_partial[%0d]: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", j, cap_an[j], cap_seg[j], cap_dp[j], e[11:8], e[7:1], e[0]);
            end
        end
        do_load(16'h12AF, 4'hF, 4'b0010);
        wait_frame("dp");
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_at(j, 4'hF, {G1, G2, GA, GF}, 4'b0010);
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== e) begin
                n_fail++;
                $display("FAIL en_dp[%0d]: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", j, cap_an[j], cap_seg[j], cap_dp[j], e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_leading_zeros();
        logic [11:0] e;
        logic [3:0]  lit;
`ifdef SEG7_LZ_BLANK_EN
        lit = 4'b0011;
`else
        lit = 4'b1111;
`endif
        do_load(16'h0030, 4'hF, 4'hF);
        wait_frame("lz");
        capture(32);
        for (int j = 0; j < 32; j++) begin
            e = exp_at(j, lit, {G0, G0, G3, G0}, 4'hF);
            n_tests++;
            if ({cap_an[j], cap_seg[j], cap_dp[j]} !== e) begin
                n_fail++;
                $display("FAIL lz[%0d]: an=%b seg=%b dp=%b, want an=%b seg=%b dp=%b", j, cap_an[j], cap_seg[j], cap_dp[j], e[11:8], e[7:1], e[0]);
            end
        end
    endtask

    task automatic test_invariant();
        logic [3:0] prev_an;
        int         off_run;
        bit         seen;
        prev_an = 4'hF;
        off_run = 0;
        seen    = 1'b0;
        for (int c = 0; c < 3200; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.value    = 16'($urandom);
                bus.digit_en = 4'($urandom);
                bus.dp_in    = 4'($urandom);
                bus.load     = 1'b1;
            end else begin
                bus.load = 1'b0;
            end
            @(negedge clk);
            n_tests++;
            if ($countones(~bus.an) > 1) begin
                n_fail++;
                $display("FAIL inv_onehot[%0d]: an=%b, want at most one low", c, bus.an);
            end
            if (bus.an != 4'hF) begin
                if (prev_an == 4'hF && seen) begin
                    n_tests++;
                    if (off_run < 2) begin
                        n_fail++;
                        $display("FAIL inv_gap[%0d]: off run %0d, want >= 2", c, off_run);
                    end
                end else if (prev_an != 4'hF) begin
                    n_tests++;
                    if (prev_an !== bus.an) begin
                        n_fail++;
                        $display("FAIL inv_switch[%0d]: an=%b after %b, want no gap-free switch", c, bus.an, prev_an);
                    end
                end
                seen    = 1'b1;
                off_run = 0;
            end else begin
                off_run++;
            end
            prev_an = bus.an;
        end
        bus.load = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_basic_scan();
        test_tearing();
        test_boundary_load();
        test_enables_dp();
        test_leading_zeros();
        test_invariant();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seg7_scan_controller.md
# seg7_scan_controller

Time-multiplexed scan controller for a common-anode multi-digit seven-segment display. It takes a packed hex value, per-digit enables and decimal points from user logic, and drives one digit at a time. A dead-time blanking interval precedes each digit to prevent ghosting, and new data is committed only at frame boundaries so there is no tearing. It sits between the design's counter/state logic and the board's `an`/`seg`/`dp` pins, and replaces ad-hoc single-digit drive.

## Interface
- `NUM_DIGITS`, default 4: digits scanned, legal range 1..8.
- `REFRESH_DIV`, default 100000: clock cycles per digit slot (1 ms at 100 MHz).
- `BLANK_CYCLES`, default 1000: dead-time cycles at the start of each slot. Must satisfy 1 ≤ `BLANK_CYCLES` < `REFRESH_DIV`.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `value`  in  4*NUM_DIGITS  hex nibbles; nibble i (`value[4i+3:4i]`) drives digit i, and digit 0 is the rightmost.
- `digit_en`  in  NUM_DIGITS  per-digit enable; 0 keeps that anode off.
- `dp_in`  in  NUM_DIGITS  per-digit decimal point; 1 means lit.
- `load`  in  1  one-cycle strobe that captures `value`/`digit_en`/`dp_in` into the pending register.
- `an`  out  NUM_DIGITS  anodes, active-low.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `frame_done`  out  1  one-cycle pulse at each frame boundary.

## Operation
- Registers:
  - pending set: value, en, dp, and a `pend_valid` flag.
  - active set: value, en, dp.
  - slot counter: 0..REFRESH_DIV-1.
  - digit index: 0..NUM_DIGITS-1.
  - state: BLANK or DRIVE.
- Slot behaviour:
  - BLANK while the slot counter is < `BLANK_CYCLES`, otherwise DRIVE.
  - At counter = REFRESH_DIV-1 the counter wraps to 0 and the index increments.
  - The index wraps from NUM_DIGITS-1 to 0.
- Frame boundary: the cycle where the counter wraps and the index is NUM_DIGITS-1.
  - `frame_done` = 1 on that cycle.
  - If `pend_valid`, the pending set is copied to the active set and `pend_valid` clears.
- `load` rules:
  - Overwrites the pending set and sets `pend_valid`. The latest load before a boundary wins.
  - If `load` is high on the boundary cycle, the new inputs bypass pending and commit directly to the active set; `pend_valid` ends 0.
- Drive during DRIVE for index i:
  - `an[i]` = ~active_en[i]; all other anodes = 1.
  - `seg` = hex glyph of active nibble i. The glyph table is the team's standard active-low table: 0→1000000, 1→1111001, 8→0000000, A→0001000, F→0001110, full 0–F.
  - `dp` = ~active_dp[i].
- During BLANK: `an` all 1, `seg` = 7'h7F, `dp` = 1.
- A disabled digit behaves as BLANK for its whole slot; the slot timing is unchanged.
- `load` has no effect on scan timing.

## Timing
- All outputs are registered. Outputs reflect the state/index of the previous cycle, i.e. one cycle of latency from the counter.
- Reset values, applied immediately and asynchronously:
  - `an` = all 1, `seg` = 7'h7F, `dp` = 1, `frame_done` = 0.
  - Counter = 0, index = 0, state = BLANK.
  - Active and pending sets = 0, `pend_valid` = 0.
  - The display is dark until the first commit.
- After `rst_n` deasserts, the first frame boundary is NUM_DIGITS*REFRESH_DIV cycles later. Frame period = NUM_DIGITS*REFRESH_DIV cycles exactly.
- Latency from `load` to visible data: at most one frame plus one cycle.
- Reset asserted mid-frame: all state returns to reset values and the pending load is discarded.
- Anode switch guarantee: no two anodes are ever low in the same cycle, and at least `BLANK_CYCLES` all-off cycles separate any two driven digits.

## Configuration
- `SEG7_LZ_BLANK_EN` defined: leading-zero suppression.
  - An enabled digit i > 0 is treated as disabled when nibbles i..NUM_DIGITS-1 of the active value are all zero.
  - Digit 0 is never suppressed.
  - `dp` of a suppressed digit is also forced off.
- `SEG7_LZ_BLANK_EN` undefined: every enabled digit shows its nibble, including leading zeros.

## Test plan
- **Reset:** hold `rst_n`=0 mid-DRIVE → same cycle `an`=1111, `seg`=7'h7F, `dp`=1, `frame_done`=0. After release, the first `frame_done` arrives 4*REFRESH_DIV cycles later.
- **Basic scan:** REFRESH_DIV=8, BLANK_CYCLES=2, load `value`=16'h12AF, `digit_en`=4'hF, `dp_in`=0, then wait for the commit. Slot 0 → 2 cycles all-off, then 6 cycles `an`=1110, `seg`=0001110. Slot 1 → `an`=1101, `seg`=0001000. Slot 2 → `an`=1011, `seg`=0100100. Slot 3 → `an`=0111, `seg`=1111001.
- **Tearing/commit:** two loads in one frame (16'h1111 then 16'h2222) → the display shows the old data until `frame_done`, then 2222 only. A load on the boundary cycle commits in that same boundary.
- **Enables and dp:** `digit_en`=4'b0101, `dp_in`=4'b0010 → `an[1]` and `an[3]` stay 1 for whole frames. `dp` is never 0, because digit 1 is disabled. Retest with `digit_en`=4'hF → `dp`=0 only during the DRIVE cycles of slot 1.
- **Leading zeros:** `value`=16'h0030, all digits enabled. With `SEG7_LZ_BLANK_EN`, digits 3 and 2 stay dark, digit 1 shows 0110000 and digit 0 shows 1000000. Without the macro, digits 3 and 2 show 1000000.
- **Invariant check:** random loads over 100 frames → never more than one anode low, and all-off runs between driven digits are ≥ BLANK_CYCLES.
